// File: rtl/reg_snap_reader.sv
// reg_snap_reader: captures {r8, r5, r2} into a shadow register on start and shifts it out
// MSB-first over a valid/ready serial link, with an optional even-parity bit at the end.
//
// Ports:
//   ck    in   system clock, rising edge
//   rn    in   asynchronous active-low reset
//   start in   capture-and-send request, ignored while busy
//   r8    in   8-bit register value
//   r5    in   5-bit register value
//   r2    in   2-bit register value
//   srdy  in   consumer ready; a bit moves on an edge with sval & srdy
//   sdo   out  serial data bit (shadow MSB)
//   sval  out  sdo valid
//   busy  out  frame in progress
//   done  out  one-cycle pulse after the last bit transfers
module reg_snap_reader #(
    parameter int PARITY = 1
) (
    input  logic       ck,
    input  logic       rn,
    input  logic       start,
    input  logic [7:0] r8,
    input  logic [4:0] r5,
    input  logic [1:0] r2,
    input  logic       srdy,
    output logic       sdo,
    output logic       sval,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0] LAST = 4'(14 + PARITY);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_n;
    logic [15:0] shadow, shadow_n;
    logic [3:0]  cnt, cnt_n;
    logic        done_n;
    logic [14:0] snap;

    assign snap = {r8, r5, r2};

    // Bit 0 of the shadow holds the parity bit; with parity disabled it is a zero
    // that is never transferred, so the shadow drains to all zeros either way.
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        cnt_n    = cnt;
        done_n   = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n  = SEND;
                shadow_n = {snap, (PARITY != 0) ? ^snap : 1'b0};
                cnt_n    = 4'd0;
            end
        end else if (srdy) begin
            shadow_n = {shadow[14:0], 1'b0};
            cnt_n    = (cnt == LAST) ? 4'd0 : cnt + 4'd1;
            if (cnt == LAST) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            state  <= IDLE;
            shadow <= 16'd0;
            cnt    <= 4'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            cnt    <= cnt_n;
            done   <= done_n;
        end
    end

    // Straight decodes of flops, so every output is glitch-free and has no input path.
    assign sdo  = shadow[15];
    assign sval = (state == SEND);
    assign busy = (state == SEND);

endmodule

// File: tb/tb_reg_snap_reader.sv
// tb_reg_snap_reader: scoreboard bench for reg_snap_reader with parity on (dut 1) and off (dut 0).
module tb_reg_snap_reader;
    logic       ck;
    logic       rn;
    logic [7:0] r8;
    logic [4:0] r5;
    logic [1:0] r2;
    logic       start [2];
    logic       srdy  [2];
    logic       sdo   [2];
    logic       sval  [2];
    logic       busy  [2];
    logic       done  [2];

    int  n_chk  = 0;
    int  n_fail = 0;
    int  rem    [2];
    bit  dexp   [2];
    bit  fresh  [2];
    bit  rnd    = 0;
    logic q0 [$];
    logic q1 [$];

    reg_snap_reader #(.PARITY(0)) u0 (
        .ck(ck), .rn(rn), .start(start[0]), .r8(r8), .r5(r5), .r2(r2), .srdy(srdy[0]),
        .sdo(sdo[0]), .sval(sval[0]), .busy(busy[0]), .done(done[0])
    );

    reg_snap_reader #(.PARITY(1)) u1 (
        .ck(ck), .rn(rn), .start(start[1]), .r8(r8), .r5(r5), .r2(r2), .srdy(srdy[1]),
        .sdo(sdo[1]), .sval(sval[1]), .busy(busy[1]), .done(done[1])
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string nm, input int d, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, d, $time, got, exp);
        end
    endtask

    function automatic int q_size(input int d);
        return (d == 1) ? q1.size() : q0.size();
    endfunction

    function automatic logic q_head(input int d);
        return (d == 1) ? q1[0] : q0[0];
    endfunction

    function automatic logic q_pop(input int d);
        if (d == 1) return q1.pop_front();
        return q0.pop_front();
    endfunction

    function automatic void q_clear(input int d);
        if (d == 1) q1.delete();
        else q0.delete();
    endfunction

    // Reference frame: r8, r5, r2 MSB-first, then a bit making the count of ones even.
    task automatic push_frame(input int d);
        logic b [$];
        logic [14:0] v;
        v = {r8, r5, r2};
        for (int i = 14; i >= 0; i--) b.push_back(v[i]);
        if (d == 1) b.push_back(($countones(v) % 2) == 1);
        foreach (b[i]) begin
            if (d == 1) q1.push_back(b[i]);
            else q0.push_back(b[i]);
        end
    endtask

    task automatic cyc();
        @(posedge ck);
        #2;
        if (rnd) for (int d = 0; d < 2; d++) srdy[d] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int d, input logic [7:0] a, input logic [4:0] b, input logic [1:0] c);
        r8 = a;
        r5 = b;
        r2 = c;
        start[d] = 1'b1;
        if (rem[d] == 0 && rn) push_frame(d);
        cyc();
        start[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 300 && rem[d] != 0; i++) cyc();
        chk("idle_timeout", d, rem[d], 0);
    endtask

    // Monitor: rem mirrors the frame state of the current cycle and is advanced for the
    // coming edge after the checks.
    always @(negedge ck) begin
        for (int d = 0; d < 2; d++) begin
            if (!rn) begin
                q_clear(d);
                rem[d]   = 0;
                dexp[d]  = 0;
                fresh[d] = 1;
            end
            chk("sval", d, sval[d], rem[d] > 0);
            chk("busy", d, busy[d], rem[d] > 0);
            chk("done", d, done[d], dexp[d]);
            if (fresh[d]) chk("idle_sdo", d, sdo[d], 0);
            dexp[d] = 0;
            if (rn && rem[d] > 0) begin
                if (q_size(d) == 0) chk("queue_empty", d, 0, 1);
                else if (srdy[d]) begin
                    chk("bit", d, sdo[d], q_pop(d));
                    rem[d]--;
                    dexp[d] = (rem[d] == 0);
                end else chk("stall_sdo", d, sdo[d], q_head(d));
            end else if (rn && start[d]) begin
                rem[d]   = (d == 1) ? 16 : 15;
                fresh[d] = 0;
            end
        end
    end

    initial begin
        rn = 1'b0;
        r8 = '0;
        r5 = '0;
        r2 = '0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            srdy[d]  = 1'b1;
            rem[d]   = 0;
            dexp[d]  = 0;
            fresh[d] = 1;
        end
        repeat (3) cyc();
        rn = 1'b1;
        repeat (2) cyc();
        rn = 1'b0;
        repeat (2) cyc();
        rn = 1'b1;
        repeat (20) cyc();

        send(1, 8'hA5, 5'h13, 2'd2);
        wait_idle(1);
        cyc();

        send(1, 8'h01, 5'h00, 2'd0);
        r8 = 8'hFF;
        wait_idle(1);
        cyc();

        send(1, 8'hA5, 5'h13, 2'd2);
        for (int c = 0; c < 26; c++) begin
            srdy[1] = !(c == 3 || c == 4 || c == 12 || c == 13);
            cyc();
        end
        srdy[1] = 1'b1;
        wait_idle(1);

        send(1, 8'h3C, 5'h0A, 2'd1);
        repeat (5) cyc();
        start[1] = 1'b1;
        cyc();
        start[1] = 1'b0;
        wait_idle(1);
        send(1, 8'hC3, 5'h15, 2'd3);
        wait_idle(1);

        send(1, 8'h5A, 5'h1F, 2'd1);
        repeat (7) cyc();
        rn = 1'b0;
        cyc();
        rn = 1'b1;
        cyc();
        send(1, 8'h96, 5'h07, 2'd2);
        wait_idle(1);

        send(0, 8'hA5, 5'h13, 2'd2);
        wait_idle(0);
        send(0, 8'hFF, 5'h1F, 2'd3);
        wait_idle(0);

        rnd = 1;
        for (int i = 0; i < 30; i++) begin
            int d;
            d = $urandom_range(0, 1);
            wait_idle(d);
            send(d, 8'($urandom), 5'($urandom), 2'($urandom));
            if ($urandom_range(0, 2) == 0) cyc();
        end
        wait_idle(0);
        wait_idle(1);
        rnd = 0;
        repeat (3) cyc();
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
